gemm_result_reader: RTL and testbench
=====================================

Name: gemm_result_reader

Overview:
- Read-back engine on the far side of the GEMM output memory C. The accelerator writes C; this block reads it.
- After a GEMM completes, start_i launches a row-major sweep of the M x N result region through C's single read port.
- Read data streams out over a valid/ready interface with row and frame markers, for host/DMA drain or bench scoreboarding.
- Tolerates arbitrary output backpressure; no beat is lost or duplicated.

Parameters:
- OutDataWidth, 32, width of one C element and of m_data_o.
- DataDepth, 4096, C memory depth in words.
- AddrWidth, $clog2(DataDepth) (1 if DataDepth<=1), C address width.
- SizeAddrWidth, 32, width of M/N size inputs.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  launch pulse, sampled only in IDLE.
- M_size_i  in  SizeAddrWidth  rows to read, captured on accepted start.
- N_size_i  in  SizeAddrWidth  columns per row, captured on accepted start.
- base_addr_i  in  AddrWidth  word address of C[0][0], captured on accepted start.
- sram_c_addr_o  out  AddrWidth  C read address. Memory returns data one cycle later.
- sram_c_rdata_i  in  OutDataWidth  C read data for the address presented the previous cycle.
- m_valid_o  out  1  output beat valid.
- m_ready_i  in  1  consumer ready; a beat transfers when valid&&ready at a rising edge.
- m_data_o  out  OutDataWidth  element C[m][n].
- m_row_last_o  out  1  beat is n==N-1.
- m_last_o  out  1  beat is the final element, m==M-1 and n==N-1.
- busy_o  out  1  high from accepted start until done_o.
- done_o  out  1  one-cycle pulse when the sweep is fully drained.

Behaviour:
Reset (rst_i=1, async):
- State goes to IDLE; counters and FIFO clear.
- Outputs: sram_c_addr_o=0, m_valid_o=0, m_data_o=0, m_row_last_o=0, m_last_o=0, busy_o=0, done_o=0.
- Reset mid-sweep aborts immediately. No done_o pulse follows.

State machine:
- IDLE: wait for start_i.
- RUN: issue reads.
- DRAIN: wait until in-flight reads and FIFO are empty.
- DONE: one cycle, then IDLE.

Transitions:
- IDLE -> RUN on start_i when M*N != 0. Sizes and base are captured; total = M*N is computed at 2*SizeAddrWidth bits.
- IDLE -> DONE on start_i when M==0 or N==0. No reads, no beats; done_o pulses the next cycle.
- RUN -> DRAIN in the cycle the last read issues.
- DRAIN -> DONE when the in-flight read has landed and the FIFO is empty.
- DONE -> IDLE. done_o=1 and busy_o=1 during DONE.
- start_i outside IDLE is ignored.

Read issue:
- Address = base + m*N + n, advanced n-fastest and truncated to AddrWidth, so it wraps modulo 2^AddrWidth. The caller keeps the region within DataDepth.
- Each read tags a row_last/last flag.
- The address is held, and no read is counted as issued, when credit is unavailable.
- Credit rule: in-flight reads (0 or 1) + FIFO occupancy < 2.

Buffering:
- 2-entry FIFO {data, row_last, last}.
- sram_c_rdata_i is pushed the cycle after issue.
- Head of FIFO drives m_*; m_valid_o = FIFO non-empty.
- m_data_o and the flags are stable while valid && !ready.
- Push and pop in the same cycle are allowed; occupancy is unchanged.

Latency and throughput:
- Start accepted at edge E0: first address driven after E0; data captured at E2; m_valid_o high after E2.
- With m_ready_i held high, one beat per cycle. M*N beats complete in M*N+2 cycles after E0; done_o follows the cycle after the last transfer.

Stall:
- When m_ready_i drops with the FIFO full, reads stop and no address advances.
- Resumption needs no bubble beyond the 1-cycle read latency.

Test Plan:
- M=4, N=16, base=0, C[i]=i, m_ready_i=1 -> 64 beats with data 0..63 in order. m_row_last_o on beats 15/31/47/63; m_last_o only on beat 63. m_valid_o first high 2 cycles after start; done_o pulses 1 cycle after beat 63; busy_o low after.
- Same load with m_ready_i random 50% -> identical beat sequence. Data and flags are held stable through every stall. FIFO never exceeds 2 entries.
- M=0, N=16 and M=3, N=0 -> no m_valid_o. done_o 1 cycle after start; zero C reads counted.
- base=4090, M=1, N=10 -> addresses 4090..4095, then 0..3 (wrap); data matches those words.
- start_i pulsed again mid-sweep (M=4, N=16) -> ignored. Exactly 64 beats, one done_o.
- rst_i asserted mid-sweep with m_ready_i=0 -> all outputs 0 immediately with no done_o. A new start (M=1, N=1, C[base]=0xDEADBEEF) returns one beat with last=1, row_last=1.

Source files
------------

// File: rtl/gemm_result_reader.sv
// Drains the M x N result region of GEMM memory C in row-major order.
// Reads are credit-limited into a 2-entry FIFO that feeds a valid/ready stream.
module gemm_result_reader #(
  parameter int OutDataWidth  = 32,
  parameter int DataDepth     = 4096,
  parameter int AddrWidth     = (DataDepth <= 1) ? 1 : $clog2(DataDepth),
  parameter int SizeAddrWidth = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  input  logic [AddrWidth-1:0]     base_addr_i,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  input  logic [OutDataWidth-1:0]  sram_c_rdata_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [OutDataWidth-1:0]  m_data_o,
  output logic                     m_row_last_o,
  output logic                     m_last_o,
  output logic                     busy_o,
  output logic                     done_o
);

  // state | meaning
  // IDLE  | waiting for start_i
  // RUN   | issuing reads into C
  // DRAIN | all reads issued, waiting for read return and FIFO to empty
  // DONE  | one-cycle completion pulse
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int TotalWidth = 2 * SizeAddrWidth;
  localparam int EntryWidth = OutDataWidth + 2;

  logic [1:0]               state_q, state_d;
  logic [SizeAddrWidth-1:0] n_size_q;
  logic [SizeAddrWidth-1:0] n_cnt_q;
  logic [TotalWidth-1:0]    total_q;
  logic [TotalWidth-1:0]    issued_q;
  logic [AddrWidth-1:0]     addr_q;
  logic                     inflight_q;
  logic                     tag_row_last_q;
  logic                     tag_last_q;

  logic [EntryWidth-1:0]    fifo_q [2];
  logic                     wr_ptr_q;
  logic                     rd_ptr_q;
  logic [1:0]               count_q;

  logic [TotalWidth-1:0]    total_in;
  logic [2:0]               pending;
  logic                     pop;
  logic                     credit;
  logic                     issue;
  logic                     row_end;
  logic                     last_issue;
  logic                     drained;
  logic [EntryWidth-1:0]    head;

  assign total_in   = TotalWidth'(M_size_i) * TotalWidth'(N_size_i);
  assign head       = fifo_q[rd_ptr_q];
  assign m_valid_o  = (count_q != 2'd0);
  assign pop        = m_valid_o && m_ready_i;

  // A beat leaving this cycle frees its slot, which keeps one beat per cycle flowing.
  assign pending    = 3'(inflight_q) + 3'(count_q) - 3'(pop);
  assign credit     = (pending < 3'd2);
  assign issue      = (state_q == S_RUN) && credit;
  assign row_end    = (n_cnt_q == n_size_q - 1'b1);
  assign last_issue = (issued_q == total_q - 1'b1);
  assign drained    = !inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop));

  assign sram_c_addr_o = addr_q;
  assign m_data_o      = m_valid_o ? head[EntryWidth-1:2] : '0;
  assign m_row_last_o  = m_valid_o ? head[1] : 1'b0;
  assign m_last_o      = m_valid_o ? head[0] : 1'b0;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = (total_in != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (issue && last_issue) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drained) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      n_size_q       <= '0;
      n_cnt_q        <= '0;
      total_q        <= '0;
      issued_q       <= '0;
      addr_q         <= '0;
      inflight_q     <= 1'b0;
      tag_row_last_q <= 1'b0;
      tag_last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (state_q == S_IDLE && start_i) begin
        n_size_q <= N_size_i;
        total_q  <= total_in;
        n_cnt_q  <= '0;
        issued_q <= '0;
        addr_q   <= base_addr_i;
      end else if (issue) begin
        tag_row_last_q <= row_end;
        tag_last_q     <= last_issue;
        issued_q       <= issued_q + 1'b1;
        addr_q         <= addr_q + 1'b1;
        n_cnt_q        <= row_end ? '0 : n_cnt_q + 1'b1;
      end
    end
  end

  // Read data lands one cycle after issue and is pushed unconditionally; credit guarantees room.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= {sram_c_rdata_i, tag_row_last_q, tag_last_q};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(inflight_q) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_gemm_result_reader.sv
// Directed sweeps with randomized data and backpressure, scored against a
// reference built from the row-major region definition and a simple memory model.
module tb_gemm_result_reader;
  localparam int DW    = 32;
  localparam int DEPTH = 4096;
  localparam int AW    = 12;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [31:0]   M_size_i, N_size_i;
  logic [AW-1:0] base_addr_i;
  logic [AW-1:0] sram_c_addr_o;
  logic [DW-1:0] sram_c_rdata_i;
  logic          m_valid_o, m_ready_i;
  logic [DW-1:0] m_data_o;
  logic          m_row_last_o, m_last_o, busy_o, done_o;

  logic [DW-1:0] mem [DEPTH];
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) sram_c_rdata_i <= mem[sram_c_addr_o];

  gemm_result_reader dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .M_size_i(M_size_i), .N_size_i(N_size_i), .base_addr_i(base_addr_i),
    .sram_c_addr_o(sram_c_addr_o), .sram_c_rdata_i(sram_c_rdata_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_row_last_o(m_row_last_o), .m_last_o(m_last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one sweep; pct is the per-cycle probability (percent) that m_ready_i is high.
  task automatic sweep(input int m, input int n, input int base, input int pct, input bit restart);
    logic [DW+1:0] exp_q [$];
    logic [DW+1:0] beat, held;
    bit   hold = 1'b0;
    int   k = 0, first_valid = -1, last_xfer = -1, done_k = -1, beats = 0;
    int   limit = 30 * m * n + 40;
    for (int i = 0; i < m * n; i++)
      exp_q.push_back({mem[(base + i) % DEPTH], (i % n) == n - 1, i == m * n - 1});

    @(negedge clk);
    M_size_i = m; N_size_i = n; base_addr_i = AW'(base); start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1'b1);
    forever begin
      beat = {m_data_o, m_row_last_o, m_last_o};
      if (done_o) begin
        done_k = k;
        break;
      end
      if (m_valid_o && first_valid < 0) first_valid = k;
      if (hold) begin
        chk("stall_valid_held", m_valid_o, 1'b1);
        chk("stall_beat_stable", beat, held);
      end
      m_ready_i = ($urandom_range(99) < pct);
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) chk("extra_beat", beats, m * n);
        else chk($sformatf("beat%0d", beats), beat, exp_q.pop_front());
        beats++;
        last_xfer = k;
      end
      hold = m_valid_o && !m_ready_i;
      held = beat;
      start_i = (restart && k == 10);
      k++;
      if (k > limit) begin
        chk("done_timeout", k, limit);
        break;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    chk("beat_count", beats, m * n);
    if (m * n == 0) begin
      chk("zero_done_latency", done_k, 0);
      chk("zero_no_valid", first_valid, -1);
    end else begin
      chk("done_after_last_xfer", done_k, last_xfer + 1);
      if (pct == 100) begin
        chk("first_valid_latency", first_valid, 2);
        chk("last_xfer_cycle", last_xfer, m * n + 1);
      end
    end
    m_ready_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("idle_after_done", {done_o, busy_o, m_valid_o}, 3'b000);
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; m_ready_i = 1'b0;
    M_size_i = '0; N_size_i = '0; base_addr_i = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    @(negedge clk);
    chk("reset_outputs",
        {sram_c_addr_o, m_valid_o, m_data_o, m_row_last_o, m_last_o, busy_o, done_o}, '0);
    rst_i = 1'b0;

    sweep(4, 16, 0, 100, 1'b0);
    sweep(4, 16, 0, 50, 1'b0);
    sweep(0, 16, 0, 100, 1'b0);
    sweep(3, 0, 0, 100, 1'b0);

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    sweep(1, 10, 4090, 70, 1'b0);
    sweep(4, 16, 1000, 100, 1'b1);
    sweep(3, 5, 77, 30, 1'b0);

    // Abort a stalled sweep with reset, then run a single-element sweep.
    m_ready_i = 1'b0;
    @(negedge clk);
    M_size_i = 4; N_size_i = 16; base_addr_i = '0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("stalled_valid", m_valid_o, 1'b1);
    #2 rst_i = 1'b1;
    #1 chk("reset_abort_outputs",
           {sram_c_addr_o, m_valid_o, m_data_o, m_row_last_o, m_last_o, busy_o, done_o}, '0);
    @(negedge clk);
    rst_i = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("no_done_after_abort", {done_o, busy_o, m_valid_o}, 3'b000);
    end
    mem[200] = 32'hDEADBEEF;
    sweep(1, 1, 200, 100, 1'b0);

    $display("%0d/%0d checks passed", passes, passes + fails);
    $finish;
  end
endmodule
